kap_issue_seq: RTL and testbench
================================

# kap_issue_seq

Upstream issue sequencer for the kap control fork. Buffers kap instructions (config word plus repeat count) pushed by the instruction fetch side. Drives the fork controller's request/acknowledge pair once per repetition, holding the config stable for each transfer. Sits directly in front of the kap control fork: its `i_kap_*` outputs connect to the fork's `t_kap_*` target port.

## Interface
- `DEPTH`, 8: instruction FIFO entries, power of two, ≥2
- `CFG_W`, 32: kap config word width
- `REP_W`, 8: repeat-count width; instruction issues `rep+1` times
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `t_instr_req`  in  1  push request, level
- `t_instr_ack`  out  1  push accept = FIFO not full and not in reset (combinational)
- `t_instr_cfg`  in  CFG_W  config word, sampled when req&ack
- `t_instr_rep`  in  REP_W  repeat count, sampled when req&ack
- `i_kap_req`  out  1  transfer request to fork controller
- `i_kap_ack`  in  1  fork complete (may be combinational from downstream)
- `i_kap_cfg`  out  CFG_W  config of the current transfer, stable while `i_kap_req`=1
- `i_kap_last`  out  1  current transfer is final repetition of its instruction
- `hold`  in  1  inhibit loading a new instruction
- `fifo_level`  out  $clog2(DEPTH+1)  occupied entries
- `issued_cnt`  out  16  completed transfers, wraps 0xFFFF→0
- `idle`  out  1  FIFO empty and no instruction active

## Operation
- Reset values: `i_kap_req`=0, `i_kap_cfg`=0, `i_kap_last`=0, `fifo_level`=0, `issued_cnt`=0, `idle`=1, `t_instr_ack`=0 while `reset` is high, FIFO pointers=0, state IDLE.
- Push occurs when `t_instr_req & t_instr_ack`. A full FIFO refuses the push even if a pop occurs in the same cycle.
- Transfer completes in any cycle with `i_kap_req & i_kap_ack`. `issued_cnt` increments in that cycle.
- State machine (2 states):
  - **IDLE**: `i_kap_req`=0.
    - If FIFO non-empty and `hold`=0: pop the head into `cur_cfg`/`remaining`, go to ISSUE.
  - **ISSUE**: `i_kap_req`=1, `i_kap_cfg`=`cur_cfg`, `i_kap_last` = (`remaining`==0).
    - On ack with `remaining`≠0: decrement `remaining`, stay in ISSUE.
    - On ack with `remaining`==0 and FIFO non-empty and `hold`=0: pop and load the next instruction, stay in ISSUE. No bubble.
    - On ack with `remaining`==0 otherwise: go to IDLE.
- `hold` is evaluated only at load decisions. An active instruction always finishes all repetitions. `i_kap_req` never deasserts without an ack.
- Simultaneous push and pop: `fifo_level` is unchanged, and pointers advance independently.
- `idle` = FIFO empty & state IDLE (registered-state derived, no combinational path from inputs).
- Reset mid-transfer: `i_kap_req` drops immediately (async). Queued instructions and repeat state are discarded.

## Timing
- Push into an empty FIFO while IDLE in cycle N: `fifo_level`=1 at N+1, load at N+1, `i_kap_req`=1 from N+2.
- `i_kap_ack` high in the same cycle `i_kap_req` rises completes that transfer. Minimum one cycle per transfer, sustained one transfer per cycle under continuous ack.
- `t_instr_ack` is combinational from the registered full flag only.
- No combinational path from `i_kap_ack` to `i_kap_req`, `i_kap_cfg` or `i_kap_last`. All three are register outputs, so the fork's combinational ack cannot form a loop.

## Structure
- Package `kap_issue_pkg`:
  - state enum (`KIS_IDLE`, `KIS_ISSUE`)
  - default width localparams `KAP_CFG_W`=32, `KAP_REP_W`=8
  - `issued_cnt` width 16
- Sub-module `kap_issue_fifo`:
  - synchronous FIFO, width CFG_W+REP_W, depth DEPTH
  - push/pop/full/empty/level, async active-high reset
- Top holds the FSM, current-instruction registers and the counter.

## Test plan
- **Single instruction**: push cfg=0xA5A5_0001, rep=0; ack held high → exactly one transfer, `i_kap_last`=1, `idle`=1 two cycles later, `issued_cnt`=1.
- **Repeat with stalling ack**: push rep=3, ack high only every third cycle → 4 transfers, cfg constant, `i_kap_last` only on the 4th, req never drops between them.
- **Back-to-back**: push 3 instructions rep=0, ack tied high → req continuous for 3 cycles with cfgs in push order, no bubble.
- **Full FIFO**: push DEPTH+1 entries with hold=1 → `t_instr_ack`=0 on the last one, `fifo_level`=DEPTH. Push and pop at full in the same cycle → push refused.
- **Hold**: assert hold during rep=2 instruction with another queued → all 3 repetitions complete, then IDLE. Release hold → next loads one cycle later.
- **Reset mid-transfer**: assert reset with req high and 2 queued → req=0 immediately, `fifo_level`=0, `issued_cnt`=0. After release, no request until a new push.

Source files
------------

// File: rtl/kap_issue_pkg.sv
// Shared types and default widths for the kap issue sequencer.
// The FIFO and the top-level FSM both import this package.
package kap_issue_pkg;

   localparam int KAP_CFG_W = 32;
   localparam int KAP_REP_W = 8;
   localparam int KAP_CNT_W = 16;

   typedef enum logic {
      KIS_IDLE  = 1'b0,
      KIS_ISSUE = 1'b1
   } kis_state_e;

   // The completed-transfer counter wraps 0xFFFF -> 0.
   function automatic logic [KAP_CNT_W-1:0] kis_cnt_inc(input logic [KAP_CNT_W-1:0] cnt);
      return cnt + 16'd1;
   endfunction

endpackage

// File: rtl/kap_issue_fifo.sv
// Synchronous instruction FIFO. Occupancy, full and empty are held in registers,
// so the upstream accept signal never depends on the same-cycle pop.
module kap_issue_fifo
   import kap_issue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int W     = KAP_CFG_W + KAP_REP_W,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_d;
   logic          full_q;
   logic          empty_q;
   logic          push_s;
   logic          pop_s;

   // Gate requests against the registered flags.
   always_comb begin
      push_s = push_i & ~full_q;
      pop_s  = pop_i & ~empty_q;
   end

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      level_d = level_q;
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Pointers, occupancy and flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q <= level_d;
         full_q  <= (level_d == LW'(DEPTH));
         empty_q <= (level_d == LW'(0));
      end
   end

   // Storage needs no reset: pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;

endmodule

// File: rtl/kap_issue_seq.sv
// Issue sequencer: queues kap instructions and replays each one rep+1 times
// on a registered req/ack handshake towards the kap control fork.
module kap_issue_seq
   import kap_issue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CFG_W = KAP_CFG_W,
   parameter int REP_W = KAP_REP_W,
   localparam int LW   = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 t_instr_req,
   output logic                 t_instr_ack,
   input  logic [CFG_W-1:0]     t_instr_cfg,
   input  logic [REP_W-1:0]     t_instr_rep,
   output logic                 i_kap_req,
   input  logic                 i_kap_ack,
   output logic [CFG_W-1:0]     i_kap_cfg,
   output logic                 i_kap_last,
   input  logic                 hold,
   output logic [LW-1:0]        fifo_level,
   output logic [KAP_CNT_W-1:0] issued_cnt,
   output logic                 idle
);

   localparam int FW = CFG_W + REP_W;

   kis_state_e           state_q;
   logic [CFG_W-1:0]     cur_cfg_q;
   logic [REP_W-1:0]     rem_q;
   logic                 req_q;
   logic                 last_q;
   logic [KAP_CNT_W-1:0] cnt_q;

   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic                 push_s;
   logic                 load_s;
   logic                 xfer_s;
   logic [FW-1:0]        fifo_wdata_s;
   logic [FW-1:0]        fifo_rdata_s;
   logic [CFG_W-1:0]     head_cfg_s;
   logic [REP_W-1:0]     head_rep_s;

   assign t_instr_ack  = ~fifo_full_s & ~reset;
   assign push_s       = t_instr_req & t_instr_ack;
   assign fifo_wdata_s = {t_instr_cfg, t_instr_rep};
   assign head_cfg_s   = fifo_rdata_s[FW-1:REP_W];
   assign head_rep_s   = fifo_rdata_s[REP_W-1:0];

   kap_issue_fifo #(
      .DEPTH (DEPTH),
      .W     (FW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_s),
      .wdata_i (fifo_wdata_s),
      .pop_i   (load_s),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .level_o (fifo_level)
   );

   // Load decision: from IDLE, or back-to-back after the final repetition.
   always_comb begin
      xfer_s = req_q & i_kap_ack;
      load_s = 1'b0;
      if (!fifo_empty_s && !hold) begin
         if (state_q == KIS_IDLE) begin
            load_s = 1'b1;
         end else if (xfer_s && (rem_q == REP_W'(0))) begin
            load_s = 1'b1;
         end else begin
            load_s = 1'b0;
         end
      end else begin
         load_s = 1'b0;
      end
   end

   // Issue FSM; req/cfg/last are registered so downstream ack cannot loop back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= KIS_IDLE;
         cur_cfg_q <= '0;
         rem_q     <= '0;
         req_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         case (state_q)
            KIS_IDLE: begin
               if (load_s) begin
                  state_q   <= KIS_ISSUE;
                  req_q     <= 1'b1;
                  cur_cfg_q <= head_cfg_s;
                  rem_q     <= head_rep_s;
                  last_q    <= (head_rep_s == REP_W'(0));
               end else begin
                  req_q  <= 1'b0;
                  last_q <= 1'b0;
               end
            end
            KIS_ISSUE: begin
               if (xfer_s) begin
                  if (rem_q != REP_W'(0)) begin
                     rem_q  <= rem_q - REP_W'(1);
                     last_q <= (rem_q == REP_W'(1));
                  end else if (load_s) begin
                     cur_cfg_q <= head_cfg_s;
                     rem_q     <= head_rep_s;
                     last_q    <= (head_rep_s == REP_W'(0));
                  end else begin
                     state_q <= KIS_IDLE;
                     req_q   <= 1'b0;
                     last_q  <= 1'b0;
                  end
               end else begin
                  req_q <= 1'b1;
               end
            end
            default: begin
               state_q <= KIS_IDLE;
               req_q   <= 1'b0;
               last_q  <= 1'b0;
            end
         endcase
      end
   end

   // Completed-transfer counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (xfer_s) begin
         cnt_q <= kis_cnt_inc(cnt_q);
      end
   end

   assign i_kap_req  = req_q;
   assign i_kap_cfg  = cur_cfg_q;
   assign i_kap_last = last_q;
   assign issued_cnt = cnt_q;
   assign idle       = fifo_empty_s & (state_q == KIS_IDLE);

endmodule

// File: tb/tb_kap_issue_seq.sv
// Scoreboard bench: every accepted instruction expands into rep+1 expected
// transfers; a negedge monitor checks each completed handshake in order.
module tb_kap_issue_seq;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH + 1);

   logic        clk = 1'b0;
   logic        reset;
   logic        t_instr_req;
   logic        t_instr_ack;
   logic [31:0] t_instr_cfg;
   logic [7:0]  t_instr_rep;
   logic        i_kap_req;
   logic        i_kap_ack;
   logic [31:0] i_kap_cfg;
   logic        i_kap_last;
   logic        hold;
   logic [LW-1:0] fifo_level;
   logic [15:0] issued_cnt;
   logic        idle;

   typedef struct {
      logic [31:0] cfg;
      logic        last;
   } xfer_t;

   xfer_t       exp_q[$];
   logic [15:0] exp_cnt;
   int          checks = 0;
   int          errors = 0;
   logic        prev_req;
   logic        prev_ack;
   logic [31:0] prev_cfg;

   always #5 clk = ~clk;

   kap_issue_seq #(.DEPTH(DEPTH), .CFG_W(32), .REP_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .t_instr_req (t_instr_req),
      .t_instr_ack (t_instr_ack),
      .t_instr_cfg (t_instr_cfg),
      .t_instr_rep (t_instr_rep),
      .i_kap_req   (i_kap_req),
      .i_kap_ack   (i_kap_ack),
      .i_kap_cfg   (i_kap_cfg),
      .i_kap_last  (i_kap_last),
      .hold        (hold),
      .fifo_level  (fifo_level),
      .issued_cnt  (issued_cnt),
      .idle        (idle)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: transfer order/content, counter, and req/cfg stability while unacked.
   always @(negedge clk) begin
      xfer_t e;
      if (reset) begin
         prev_req = 1'b0;
         prev_ack = 1'b0;
         prev_cfg = '0;
      end else begin
         chk("issued_cnt", 64'(issued_cnt), 64'(exp_cnt));
         if (prev_req && !prev_ack) begin
            chk("req_held", 64'(i_kap_req), 64'd1);
            chk("cfg_stable", 64'(i_kap_cfg), 64'(prev_cfg));
         end
         if (i_kap_req && i_kap_ack) begin
            if (exp_q.size() == 0) begin
               chk("spurious_xfer", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("xfer_cfg", 64'(i_kap_cfg), 64'(e.cfg));
               chk("xfer_last", 64'(i_kap_last), 64'(e.last));
            end
            exp_cnt = exp_cnt + 16'd1;
         end
         prev_req = i_kap_req;
         prev_ack = i_kap_ack;
         prev_cfg = i_kap_cfg;
      end
   end

   function automatic void expect_instr(input logic [31:0] cfg, input logic [7:0] rep);
      for (int i = 0; i <= int'(rep); i++) begin
         exp_q.push_back('{cfg: cfg, last: (i == int'(rep))});
      end
   endfunction

   // One-cycle push; exp_acc: 1/0 required accept, -1 don't care.
   task automatic push(input logic [31:0] cfg, input logic [7:0] rep, input int exp_acc);
      t_instr_req = 1'b1;
      t_instr_cfg = cfg;
      t_instr_rep = rep;
      @(negedge clk);
      if (exp_acc >= 0) chk("push_accept", 64'(t_instr_ack), 64'(exp_acc));
      if (t_instr_ack) expect_instr(cfg, rep);
      @(posedge clk); #1;
      t_instr_req = 1'b0;
   endtask

   task automatic wait_req();
      int n = 0;
      @(negedge clk);
      while (!i_kap_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!i_kap_req) chk("wait_req_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      hold = 1'b0;
      i_kap_ack = 1'b1;
      @(negedge clk);
      while (!(idle && exp_q.size() == 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain_idle", 64'(idle), 64'd1);
      chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_level", 64'(fifo_level), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      t_instr_req = 1'b0; t_instr_cfg = '0; t_instr_rep = '0;
      i_kap_ack = 1'b0; hold = 1'b0;
      exp_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tack", 64'(t_instr_ack), 64'd0);
      chk("rst_req", 64'(i_kap_req), 64'd0);
      chk("rst_cfg", 64'(i_kap_cfg), 64'd0);
      chk("rst_last", 64'(i_kap_last), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_cnt", 64'(issued_cnt), 64'd0);
      chk("rst_idle", 64'(idle), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      // Single instruction, ack held high.
      i_kap_ack = 1'b1;
      push(32'hA5A5_0001, 8'd0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("single_idle", 64'(idle), 64'd1);
      chk("single_cnt", 64'(issued_cnt), 64'd1);
      chk("single_sb", 64'(exp_q.size()), 64'd0);

      // Repeat count 3 with ack only every third cycle.
      i_kap_ack = 1'b0;
      push(32'h1234_5678, 8'd3, 1);
      for (int k = 0; k < 40; k++) begin
         i_kap_ack = (k % 3 == 2);
         @(posedge clk); #1;
      end
      chk("rep_cnt", 64'(issued_cnt), 64'd5);
      chk("rep_idle", 64'(idle), 64'd1);

      // Back-to-back rep=0 instructions: no bubble.
      hold = 1'b1; i_kap_ack = 1'b0;
      push(32'hB2B2_0000, 8'd0, 1);
      push(32'hB2B2_0001, 8'd0, 1);
      push(32'hB2B2_0002, 8'd0, 1);
      hold = 1'b0; i_kap_ack = 1'b1;
      wait_req();
      @(negedge clk); chk("b2b_req2", 64'(i_kap_req), 64'd1);
      @(negedge clk); chk("b2b_req3", 64'(i_kap_req), 64'd1);
      @(negedge clk); chk("b2b_req4", 64'(i_kap_req), 64'd0);
      drain();

      // Full FIFO with hold, then push+pop at full.
      hold = 1'b1; i_kap_ack = 1'b0;
      for (int i = 0; i < DEPTH; i++) push(32'hF000_0000 + 32'(i), 8'd0, 1);
      chk("full_level", 64'(fifo_level), 64'(DEPTH));
      push(32'hDEAD_BEEF, 8'd1, 0);
      hold = 1'b0; t_instr_req = 1'b1; t_instr_cfg = 32'hDEAD_0002; t_instr_rep = 8'd0;
      @(negedge clk);
      chk("full_pushpop_tack", 64'(t_instr_ack), 64'd0);
      if (t_instr_ack) expect_instr(32'hDEAD_0002, 8'd0);
      @(posedge clk); #1;
      t_instr_req = 1'b0;
      chk("full_pushpop_level", 64'(fifo_level), 64'(DEPTH - 1));
      chk("full_pushpop_req", 64'(i_kap_req), 64'd1);
      drain();

      // Hold during a rep=2 instruction with another queued.
      hold = 1'b0; i_kap_ack = 1'b0;
      push(32'hC0C0_00A0, 8'd2, 1);
      push(32'hC0C0_00B1, 8'd0, 1);
      hold = 1'b1;
      wait_req();
      @(posedge clk); #1;
      i_kap_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_cnt", 64'(issued_cnt), 64'(exp_cnt));
      repeat (2) begin
         @(negedge clk);
         chk("hold_req_low", 64'(i_kap_req), 64'd0);
         chk("hold_level", 64'(fifo_level), 64'd1);
      end
      @(posedge clk); #1;
      hold = 1'b0;
      @(posedge clk); #1;
      chk("hold_release_req", 64'(i_kap_req), 64'd1);
      drain();

      // Reset mid-transfer with two queued.
      i_kap_ack = 1'b0;
      push(32'hE000_0005, 8'd5, 1);
      push(32'hE000_0006, 8'd0, 1);
      push(32'hE000_0007, 8'd0, 1);
      wait_req();
      chk("pre_rst_level", 64'(fifo_level), 64'd2);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_req", 64'(i_kap_req), 64'd0);
      chk("mid_rst_level", 64'(fifo_level), 64'd0);
      chk("mid_rst_cnt", 64'(issued_cnt), 64'd0);
      chk("mid_rst_tack", 64'(t_instr_ack), 64'd0);
      exp_q.delete();
      exp_cnt = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      i_kap_ack = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_req", 64'(i_kap_req), 64'd0);
      end
      @(posedge clk); #1;

      // Randomized traffic.
      for (int c = 0; c < 600; c++) begin
         t_instr_req = ($urandom_range(0, 2) == 0);
         t_instr_cfg = $urandom;
         t_instr_rep = 8'($urandom_range(0, 3));
         i_kap_ack   = ($urandom_range(0, 2) != 0);
         hold        = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         if (t_instr_req && t_instr_ack) expect_instr(t_instr_cfg, t_instr_rep);
         @(posedge clk); #1;
      end
      t_instr_req = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
